// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve queue and its storage.
// The entry layout matches what the gshare predictor expects to be replayed.
package bp_pkg;

  localparam int unsigned BP_HISTORY_SIZE = 4;
  localparam logic [31:0] INSTR_BYTES     = 32'd4;

  typedef struct packed {
    logic [31:0]                pc;
    logic                       pred_taken;
    logic [31:0]                pred_target;
    logic [BP_HISTORY_SIZE-1:0] history;
  } entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic logic [31:0] actual_next_pc(input logic [31:0] pc,
                                                 input logic        taken,
                                                 input logic [31:0] target);
    logic [31:0] npc;
    if (taken) begin
      npc = target;
    end else begin
      npc = pc + INSTR_BYTES;
    end
    return npc;
  endfunction

endpackage

// File: rtl/brq_storage.sv
// Circular buffer of DEPTH entries with head/tail pointers and occupancy count.
// Clear wins over push/pop; the head entry is always visible on rdata_o.
module brq_storage
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 69
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_i) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_i) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !clear_i) begin
        mem_q[tail_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches: resolves the head against execute's
// outcome, emits a registered training packet and, on mispredict, a flush.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned HISTORY_SIZE = BP_HISTORY_SIZE
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [31:0]                alloc_pc_i,
  input  logic                       alloc_pred_taken_i,
  input  logic [31:0]                alloc_pred_target_i,
  input  logic [HISTORY_SIZE-1:0]    alloc_history_i,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  input  logic [31:0]                resolve_target_i,
  output logic                       upd_valid_o,
  output logic                       upd_taken_o,
  output logic [31:0]                upd_next_pc_o,
  output logic [HISTORY_SIZE-1:0]    upd_history_o,
  output logic                       flush_o,
  output logic [31:0]                flush_pc_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 65 + HISTORY_SIZE;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]             pc;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic [HISTORY_SIZE-1:0] history;
  } brq_entry_t;

  state_e     state_q, state_d;
  brq_entry_t alloc_entry_s, head_entry_s;
  logic [EW-1:0] head_raw_s;
  logic [CW-1:0] count_s;

  logic alloc_fire_s, resolve_fire_s, resolve_empty_s, mispredict_s;
  logic push_s, pop_s, clear_s;
  logic [31:0] actual_npc_s;

  logic                    upd_valid_q, upd_taken_q;
  logic [31:0]             upd_next_pc_q;
  logic [HISTORY_SIZE-1:0] upd_history_q;
  logic                    flush_q;
  logic [31:0]             flush_pc_q;
  logic                    err_q;

  assign alloc_entry_s = '{pc:          alloc_pc_i,
                           pred_taken:  alloc_pred_taken_i,
                           pred_target: alloc_pred_target_i,
                           history:     alloc_history_i};
  assign head_entry_s  = brq_entry_t'(head_raw_s);

  // No bypass: a full queue refuses alloc even while the head is resolving.
  assign alloc_ready_o = reset_ni && (state_q == RUN) && (count_s < DEPTH_C);

  always_comb begin
    state_d         = state_q;
    alloc_fire_s    = 1'b0;
    resolve_fire_s  = 1'b0;
    resolve_empty_s = 1'b0;
    mispredict_s    = 1'b0;
    actual_npc_s    = actual_next_pc(head_entry_s.pc, resolve_taken_i, resolve_target_i);
    case (state_q)
      RUN: begin
        alloc_fire_s    = alloc_valid_i && alloc_ready_o;
        resolve_fire_s  = resolve_valid_i && (count_s != {CW{1'b0}});
        resolve_empty_s = resolve_valid_i && (count_s == {CW{1'b0}});
        mispredict_s    = resolve_fire_s &&
                          ((head_entry_s.pred_taken != resolve_taken_i) ||
                           (resolve_taken_i && (head_entry_s.pred_target != resolve_target_i)));
        if (mispredict_s) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A mispredict squashes everything younger, including this cycle's alloc.
  assign push_s  = alloc_fire_s && !mispredict_s;
  assign pop_s   = resolve_fire_s;
  assign clear_s = mispredict_s;

  brq_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .clear_i  (clear_s),
    .wdata_i  (EW'(alloc_entry_s)),
    .rdata_o  (head_raw_s),
    .count_o  (count_s)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= RUN;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_next_pc_q <= 32'h0000_0000;
      upd_history_q <= {HISTORY_SIZE{1'b0}};
      flush_q       <= 1'b0;
      flush_pc_q    <= 32'h0000_0000;
      err_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= resolve_fire_s;
      flush_q     <= mispredict_s;
      err_q       <= err_q | resolve_empty_s;
      if (resolve_fire_s) begin
        upd_taken_q   <= resolve_taken_i;
        upd_next_pc_q <= actual_npc_s;
        upd_history_q <= head_entry_s.history;
      end
      if (mispredict_s) begin
        flush_pc_q <= actual_npc_s;
      end
    end
  end

  assign upd_valid_o   = upd_valid_q;
  assign upd_taken_o   = upd_taken_q;
  assign upd_next_pc_o = upd_next_pc_q;
  assign upd_history_o = upd_history_q;
  assign flush_o       = flush_q;
  assign flush_pc_o    = flush_pc_q;
  assign count_o       = count_s;
  assign err_o         = err_q;

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight branch predictions, sitting between fetch and the gshare predictor's training port. Fetch allocates one entry per predicted branch. Execute resolves the oldest entry with the actual outcome. The block then issues a registered training packet (taken flag, next PC, history snapshot) to the predictor and, on a mispredict, a one-cycle flush/redirect that empties the queue.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- HISTORY_SIZE, 4, width of the global-history snapshot stored per entry; matches the predictor
- clk_i  in  1  clock; all state updates on rising edge
- reset_ni  in  1  synchronous, active-low reset
- alloc_valid_i  in  1  fetch offers a predicted branch
- alloc_ready_o  out  1  entry can be accepted this cycle
- alloc_pc_i  in  32  branch PC
- alloc_pred_taken_i  in  1  predicted direction
- alloc_pred_target_i  in  32  predicted target
- alloc_history_i  in  HISTORY_SIZE  history used for the prediction
- resolve_valid_i  in  1  execute resolves the head entry
- resolve_taken_i  in  1  actual direction
- resolve_target_i  in  32  actual taken target
- upd_valid_o  out  1  training packet valid (1-cycle pulse)
- upd_taken_o  out  1  actual direction
- upd_next_pc_o  out  32  actual next PC
- upd_history_o  out  HISTORY_SIZE  stored history of the resolved entry
- flush_o  out  1  mispredict redirect (1-cycle pulse)
- flush_pc_o  out  32  redirect PC
- count_o  out  clog2(DEPTH)+1  occupied entries
- err_o  out  1  sticky: resolve seen while empty; cleared only by reset

## Operation
- Storage is a circular buffer with head/tail pointers of width clog2(DEPTH). Pointers wrap modulo DEPTH.
- FSM states:
  - RUN (reset state)
  - FLUSH: entered on the cycle after a mispredicting resolve; lasts exactly 1 cycle; returns to RUN.
- Alloc handshake: an entry is accepted when alloc_valid_i && alloc_ready_o.
  - alloc_ready_o = reset_ni && state==RUN && count<DEPTH.
  - No same-cycle bypass when full: a resolve in a full cycle does not free space for that cycle's alloc.
- Resolve handshake:
  - Accepted in RUN when count>0.
  - In FLUSH, resolve is ignored, with no error.
  - Resolve while in RUN with count==0 is dropped and sets err_o.
- Actual next PC:
  - resolve_target_i if resolve_taken_i is set.
  - Otherwise pc+4, computed modulo 2^32.
- Mispredict condition: pred_taken≠resolve_taken, or both taken and pred_target≠resolve_target.
- Every accepted resolve:
  - Pops the head.
  - Next cycle: upd_valid_o=1 with the packet from the popped entry.
- Mispredicting resolve:
  - Next cycle: flush_o=1 and flush_pc_o = actual next PC.
  - Queue emptied: head=tail, count=0.
  - An alloc accepted in the same cycle is discarded, because it is younger.
- Simultaneous correct resolve + alloc (not full): both take effect; count unchanged.

## Timing
- Reset values: count_o=0, err_o=0, upd_*=0, flush_o=0, flush_pc_o=0, state RUN.
- While reset_ni is low, alloc_ready_o=0.
- Pulse timing:
  - Resolve at edge N → upd_valid_o and flush_o high during cycle N+1, low at N+2 unless a new resolve occurs.
  - upd_* data and flush_pc_o hold their value until the next pulse.
- count_o is registered and reflects allocs and pops of the previous edge.
- Reset mid-operation: the next edge clears all entries, pointers, err_o and pending pulses. No packet is emitted for discarded entries.

## Structure
- Package bp_pkg:
  - entry typedef {pc[31:0], pred_taken, pred_target[31:0], history[HISTORY_SIZE-1:0]}
  - state enum {RUN, FLUSH}
  - constant INSTR_BYTES=4
- Sub-module brq_storage: DEPTH-entry register array with head/tail/count, push/pop/clear ports. The top level holds the FSM, compare logic and output registers.

## Test plan
- Reset, then alloc pc=0x100 pred NT, then resolve NT → upd_valid_o pulse with taken=0, next_pc=0x104; flush_o stays 0; count_o returns to 0.
- Alloc 4 entries (DEPTH=4) → alloc_ready_o=0 and count_o=4. A 5th alloc_valid_i is not accepted. Resolve head with a same-cycle alloc → alloc still refused that cycle.
- Alloc pc=0x200 pred T target 0x300, resolve T target 0x340 → flush_o=1 with flush_pc_o=0x340. Count drops to 0. alloc_ready_o=0 for that one cycle.
- Mispredicting resolve with a simultaneous alloc, 2 entries queued → count_o=0 afterward. The allocated entry never produces upd_valid_o.
- Resolve while empty → err_o=1 and stays 1 through later traffic until reset_ni=0 for one edge.
- Alloc pc=0xFFFFFFFC pred T, resolve NT → flush_pc_o=0x00000000 (wrap). 20 alloc/resolve pairs exercise pointer wrap with history values preserved in order.
